// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ requesters.
// Each grant is sent as a two-byte frame: a header carrying the requester ID,
// then the payload byte captured at grant time. A per-byte watchdog aborts a
// frame when uart_tx never reports completion.
module uart_tx_arbiter #(
  parameter int                 NB_DATA        = 8,
  parameter int                 NUM_REQ        = 4,
  parameter int                 ID_W           = 2,
  parameter logic [NB_DATA-1:0] HDR_PREFIX     = 8'hA0,
  parameter int                 TIMEOUT_CYCLES = 2000000,
  parameter int                 CNT_W          = 21
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NB_DATA-1:0]   req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         tx_start,
  output logic [NB_DATA-1:0]           tx_data,
  input  logic                         tx_done_tick,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_HDR  = 3'd1,
    ST_WAIT_HDR  = 3'd2,
    ST_SEND_DATA = 3'd3,
    ST_WAIT_DATA = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Registered state and outputs
  state_t               state_r;
  logic [ID_W-1:0]      last_grant_r;
  logic [ID_W-1:0]      grant_id_r;
  logic [NB_DATA-1:0]   payload_r;
  logic [CNT_W-1:0]     wd_r;
  logic [NUM_REQ-1:0]   ack_r;
  logic                 tx_start_r;
  logic [NB_DATA-1:0]   tx_data_r;
  logic                 busy_r;
  logic                 timeout_err_r;

  // Next-state values
  state_t               state_nxt_s;
  logic [ID_W-1:0]      last_grant_nxt_s;
  logic [ID_W-1:0]      grant_id_nxt_s;
  logic [NB_DATA-1:0]   payload_nxt_s;
  logic [CNT_W-1:0]     wd_nxt_s;
  logic [NUM_REQ-1:0]   ack_nxt_s;
  logic                 tx_start_nxt_s;
  logic [NB_DATA-1:0]   tx_data_nxt_s;
  logic                 busy_nxt_s;
  logic                 timeout_err_nxt_s;

  // Arbitration helpers
  int                   start_s;
  int                   pick_sum_s;
  logic [2*NUM_REQ-1:0] req_dbl_s;
  logic [NUM_REQ-1:0]   req_rot_s;
  logic [NUM_REQ-1:0]   req_low_s;
  logic                 any_req_s;
  logic [ID_W-1:0]      winner_s;
  logic [NB_DATA-1:0]   win_data_s;
  logic [NB_DATA-1:0]   header_s;
  logic                 wd_expired_s;

  assign header_s     = {HDR_PREFIX[NB_DATA-1:ID_W], grant_id_r};
  assign wd_expired_s = (wd_r == CNT_W'(TIMEOUT_CYCLES - 32'sd1));

  // Round-robin pick: rotate requests so the slot after last_grant is bit 0,
  // isolate the lowest set bit, then map its position back to a requester ID.
  always_comb begin
    start_s    = (int'(last_grant_r) + 32'sd1) % NUM_REQ;
    req_dbl_s  = {req, req};
    req_rot_s  = NUM_REQ'(req_dbl_s >> start_s);
    req_low_s  = req_rot_s & (~req_rot_s + NUM_REQ'(1'b1));
    any_req_s  = |req_rot_s;
    pick_sum_s = start_s;
    for (int j = 32'sd0; j < NUM_REQ; j++) begin
      if (req_low_s == (NUM_REQ'(1'b1) << j)) begin
        pick_sum_s = start_s + j;
      end else begin
        pick_sum_s = pick_sum_s;
      end
    end
    if (pick_sum_s >= NUM_REQ) begin
      pick_sum_s = pick_sum_s - NUM_REQ;
    end else begin
      pick_sum_s = pick_sum_s;
    end
    winner_s   = ID_W'(pick_sum_s);
    win_data_s = NB_DATA'(req_data >> (int'(winner_s) * NB_DATA));
  end

  // Frame sequencer: next state and next registered outputs
  always_comb begin
    state_nxt_s       = state_r;
    last_grant_nxt_s  = last_grant_r;
    grant_id_nxt_s    = grant_id_r;
    payload_nxt_s     = payload_r;
    wd_nxt_s          = wd_r;
    ack_nxt_s         = '0;
    tx_start_nxt_s    = 1'b0;
    tx_data_nxt_s     = tx_data_r;
    busy_nxt_s        = busy_r;
    timeout_err_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          grant_id_nxt_s = winner_s;
          busy_nxt_s     = 1'b1;
          payload_nxt_s  = win_data_s;
          state_nxt_s    = ST_SEND_HDR;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end

      ST_SEND_HDR: begin
        tx_start_nxt_s = 1'b1;
        tx_data_nxt_s  = header_s;
        wd_nxt_s       = '0;
        state_nxt_s    = ST_WAIT_HDR;
      end

      ST_WAIT_HDR: begin
        // A done arriving on the expiry cycle still counts as success.
        if (tx_done_tick) begin
          state_nxt_s       = ST_SEND_DATA;
        end else if (wd_expired_s) begin
          timeout_err_nxt_s = 1'b1;
          last_grant_nxt_s  = grant_id_r;
          busy_nxt_s        = 1'b0;
          state_nxt_s       = ST_IDLE;
        end else begin
          wd_nxt_s          = wd_r + CNT_W'(1'b1);
        end
      end

      ST_SEND_DATA: begin
        tx_start_nxt_s = 1'b1;
        tx_data_nxt_s  = payload_r;
        wd_nxt_s       = '0;
        state_nxt_s    = ST_WAIT_DATA;
      end

      ST_WAIT_DATA: begin
        if (tx_done_tick) begin
          state_nxt_s       = ST_DONE;
        end else if (wd_expired_s) begin
          timeout_err_nxt_s = 1'b1;
          last_grant_nxt_s  = grant_id_r;
          busy_nxt_s        = 1'b0;
          state_nxt_s       = ST_IDLE;
        end else begin
          wd_nxt_s          = wd_r + CNT_W'(1'b1);
        end
      end

      ST_DONE: begin
        ack_nxt_s        = NUM_REQ'(1'b1) << grant_id_r;
        last_grant_nxt_s = grant_id_r;
        busy_nxt_s       = 1'b0;
        state_nxt_s      = ST_IDLE;
      end

      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= ID_W'(NUM_REQ - 32'sd1);
      grant_id_r    <= '0;
      payload_r     <= '0;
      wd_r          <= '0;
      ack_r         <= '0;
      tx_start_r    <= 1'b0;
      tx_data_r     <= '0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      last_grant_r  <= last_grant_nxt_s;
      grant_id_r    <= grant_id_nxt_s;
      payload_r     <= payload_nxt_s;
      wd_r          <= wd_nxt_s;
      ack_r         <= ack_nxt_s;
      tx_start_r    <= tx_start_nxt_s;
      tx_data_r     <= tx_data_nxt_s;
      busy_r        <= busy_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
    end
  end

  assign ack         = ack_r;
  assign tx_start    = tx_start_r;
  assign tx_data     = tx_data_r;
  assign busy        = busy_r;
  assign grant_id    = grant_id_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of frames run through the main
// instance, plus hand sequences for reset mid-frame and the watchdog (second
// instance with a short timeout).
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        done_m, done_w;

  logic [3:0] ack_m, ack_w;
  logic       tx_start_m, tx_start_w;
  logic [7:0] tx_data_m, tx_data_w;
  logic       busy_m, busy_w;
  logic [1:0] grant_id_m, grant_id_w;
  logic       timeout_err_m, timeout_err_w;

  int checks = 0;
  int errors = 0;

  int ack_cnt_m [NR] = '{default: 0};
  int ack_cnt_w      = 0;
  int to_cnt_m       = 0;
  int snap [NR];

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  req_mid;
    logic [31:0] data_mid;
    logic [1:0]  exp_id;
    logic [7:0]  exp_hdr;
    logic [7:0]  exp_pay;
    logic [3:0]  exp_ack;
  } frame_t;

  frame_t vec [8];
  frame_t v6;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(1000), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack_m), .tx_start(tx_start_m), .tx_data(tx_data_m),
    .tx_done_tick(done_m), .busy(busy_m), .grant_id(grant_id_m),
    .timeout_err(timeout_err_m)
  );

  uart_tx_arbiter #(.TIMEOUT_CYCLES(50), .CNT_W(6)) dut_wd (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack_w), .tx_start(tx_start_w), .tx_data(tx_data_w),
    .tx_done_tick(done_w), .busy(busy_w), .grant_id(grant_id_w),
    .timeout_err(timeout_err_w)
  );

  always #5 clk = ~clk;

  // Count ack and timeout cycles seen on each instance
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (ack_m[i]) ack_cnt_m[i] <= ack_cnt_m[i] + 1;
    end
    if (ack_w != 4'b0000) ack_cnt_w <= ack_cnt_w + 1;
    if (timeout_err_m) to_cnt_m <= to_cnt_m + 1;
  end

  // Hard stop in case a wait loop is broken
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_done_m();
    done_m = 1'b1;
    @(negedge clk);
    done_m = 1'b0;
  endtask

  task automatic wait_start_m(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_start_m && n < 20);
  endtask

  task automatic wait_start_w(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_start_w && n < 20);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One full frame on the main instance; inputs already applied at a negedge
  task automatic run_frame(input frame_t v);
    int n;
    wait_start_m(n);
    check("req_to_start_latency", n, 2);
    check("header_byte", tx_data_m, v.exp_hdr);
    check("grant_id", grant_id_m, v.exp_id);
    check("busy_during_frame", busy_m, 1);
    req      = v.req_mid;
    req_data = v.data_mid;
    repeat (99) @(negedge clk);
    check("header_hold", {tx_start_m, tx_data_m}, {1'b0, v.exp_hdr});
    pulse_done_m();
    n = 0;
    while (!tx_start_m && n < 10) begin @(negedge clk); n++; end
    check("payload_latency", n, 1);
    check("payload_byte", tx_data_m, v.exp_pay);
    repeat (99) @(negedge clk);
    pulse_done_m();
    n = 0;
    while (ack_m == 4'b0000 && n < 10) begin @(negedge clk); n++; end
    check("ack_latency", n, 1);
    check("ack_value", ack_m, v.exp_ack);
    check("busy_after_frame", busy_m, 0);
  endtask

  initial begin
    int n;
    req      = 4'b0000;
    req_data = 32'h0;
    done_m   = 1'b0;
    done_w   = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs_main", {ack_m, tx_start_m, tx_data_m, busy_m, grant_id_m, timeout_err_m}, 32'h0);
    check("reset_outputs_wd", {ack_w, tx_start_w, tx_data_w, busy_w, grant_id_w, timeout_err_w}, 32'h0);
    reset = 1'b0;

    //         rst   req      data           req_mid  data_mid       id    hdr    pay    ack
    vec[0] = '{1'b1, 4'b0001, 32'h0000_005C, 4'b0001, 32'h0000_005C, 2'd0, 8'hA0, 8'h5C, 4'b0001};
    vec[1] = '{1'b1, 4'b1111, 32'h4433_2211, 4'b1111, 32'h4433_2211, 2'd0, 8'hA0, 8'h11, 4'b0001};
    vec[2] = '{1'b0, 4'b1110, 32'h4433_2211, 4'b1110, 32'h4433_2211, 2'd1, 8'hA1, 8'h22, 4'b0010};
    vec[3] = '{1'b0, 4'b1100, 32'h4433_2211, 4'b1100, 32'h4433_2211, 2'd2, 8'hA2, 8'h33, 4'b0100};
    vec[4] = '{1'b0, 4'b1000, 32'h4433_2211, 4'b1000, 32'h4433_2211, 2'd3, 8'hA3, 8'h44, 4'b1000};
    vec[5] = '{1'b0, 4'b0100, 32'h0077_0000, 4'b0101, 32'h0077_0000, 2'd2, 8'hA2, 8'h77, 4'b0100};
    vec[6] = '{1'b0, 4'b0101, 32'h0077_009A, 4'b0100, 32'h0077_00E5, 2'd0, 8'hA0, 8'h9A, 4'b0001};
    vec[7] = '{1'b0, 4'b0100, 32'h0077_0000, 4'b0100, 32'h0077_0000, 2'd2, 8'hA2, 8'h77, 4'b0100};
    v6     = '{1'b0, 4'b0001, 32'h0000_005C, 4'b0001, 32'h0000_005C, 2'd0, 8'hA0, 8'h5C, 4'b0001};

    for (int i = 0; i < 8; i++) begin
      if (vec[i].rst) begin
        req = 4'b0000;
        apply_reset();
      end
      if (i == 1) begin
        #1;
        for (int k = 0; k < NR; k++) snap[k] = ack_cnt_m[k];
      end
      req      = vec[i].req;
      req_data = vec[i].data;
      run_frame(vec[i]);
      if (i == 4) begin
        #1;
        for (int k = 0; k < NR; k++) check("one_ack_per_requester", ack_cnt_m[k] - snap[k], 1);
      end
    end
    req = 4'b0000;

    // Reset asserted while waiting for the payload done
    apply_reset();
    req      = 4'b0001;
    req_data = 32'h0000_005C;
    wait_start_m(n);
    repeat (99) @(negedge clk);
    pulse_done_m();
    wait_start_m(n);
    check("in_wait_data_payload", tx_data_m, 8'h5C);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_frame_outputs", {ack_m, tx_start_m, tx_data_m, busy_m, grant_id_m, timeout_err_m}, 32'h0);
    reset = 1'b0;
    #1;
    snap[0] = ack_cnt_m[0];
    run_frame(v6);
    #1;
    check("no_partial_ack_after_reset", ack_cnt_m[0] - snap[0], 1);
    req = 4'b0000;

    // Watchdog on the short-timeout instance
    apply_reset();
    req      = 4'b0011;
    req_data = 32'h0000_00C3;
    wait_start_w(n);
    check("wd_first_grant", grant_id_w, 0);
    n = 0;
    while (!timeout_err_w && n < 200) begin @(negedge clk); n++; end
    check("wd_timeout_latency", n, 50);
    check("wd_busy_on_timeout", busy_w, 0);
    check("wd_no_ack_on_timeout", ack_w, 0);
    @(negedge clk);
    check("wd_timeout_one_cycle", timeout_err_w, 0);
    wait_start_w(n);
    check("wd_next_grant_rotates", {grant_id_w, tx_data_w}, {2'd1, 8'hA1});
    n = 0;
    while (!timeout_err_w && n < 200) begin @(negedge clk); n++; end
    check("wd_second_timeout_latency", n, 50);
    wait_start_w(n);
    check("wd_retry_after_others", {grant_id_w, tx_data_w}, {2'd0, 8'hA0});
    // done on the expiry cycle must win over the timeout
    repeat (49) @(negedge clk);
    done_w = 1'b1;
    @(negedge clk);
    done_w = 1'b0;
    check("wd_done_beats_timeout", timeout_err_w, 0);
    @(negedge clk);
    check("wd_payload_after_late_done", {tx_start_w, tx_data_w}, {1'b1, 8'hC3});
    req = 4'b0000;
    #1;
    check("wd_no_ack_total", ack_cnt_w, 0);
    check("main_never_timed_out", to_cnt_m, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
